// File: rtl/pcie_param_loader.sv
// Host-side parameter loader: turns load commands plus a host word stream into
// layer, weight or bias RAM writes. Weight entries are packed from WPE host words.
module pcie_param_loader #(
    parameter int HOST_W   = 32,
    parameter int WEIGHT_W = 1936,
    parameter int WADDR_W  = 10,
    parameter int BIAS_W   = 16,
    parameter int BADDR_W  = 1,
    parameter int LADDR_W  = 18
) (
    input  logic                clk,
    input  logic                pcieRst,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [1:0]          cmdOp,
    input  logic [LADDR_W-1:0]  cmdAddr,
    input  logic [LADDR_W-1:0]  cmdLen,
    input  logic                cmdAbort,
    input  logic [HOST_W-1:0]   hostData,
    input  logic                hostValid,
    output logic                hostReady,
    output logic                layerWriteEn,
    output logic [HOST_W-1:0]   writeLayerData,
    output logic [LADDR_W-1:0]  layerDataAddr,
    output logic                weightWriteEn,
    output logic [WEIGHT_W-1:0] writeWeightData,
    output logic [WADDR_W-1:0]  weightDataAddr,
    output logic                biasWriteEn,
    output logic [BIAS_W-1:0]   writeBiasData,
    output logic [BADDR_W-1:0]  biasDataAddr,
    output logic                busy,
    output logic                done,
    output logic [1:0]          doneOp,
    output logic                aborted
);
    localparam int WPE    = (WEIGHT_W + HOST_W - 1) / HOST_W;
    localparam int WCNT_W = $clog2(WPE + 1);
    localparam int LAST_W = WEIGHT_W - (WPE - 1) * HOST_W;

    typedef enum logic [2:0] {IDLE, LAYER, WFILL, WWRITE, BIAS, FIN} state_t;
    state_t state, state_nxt;

    logic [1:0]          op;
    logic [LADDR_W-1:0]  base, len, entry, entry_inc, cur_addr;
    logic [WCNT_W-1:0]   word;
    logic [WEIGHT_W-1:0] pack;
    logic                accept, beat, stop, last_entry, last_word;

    assign accept     = cmdValid && cmdReady;
    assign beat       = hostValid && hostReady;
    assign stop       = cmdAbort && busy;
    assign entry_inc  = entry + 1'b1;
    assign cur_addr   = base + entry;
    assign last_entry = (entry_inc == len);
    assign last_word  = (word == WCNT_W'(WPE - 1));

    always_ff @(posedge clk or negedge pcieRst) begin
        if (!pcieRst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmdReady  = (state == IDLE);
        busy      = (state != IDLE);
        hostReady = (state == LAYER) || (state == WFILL) || (state == BIAS);
        case (state)
            IDLE: if (accept) begin
                if (cmdLen == '0 || cmdOp == 2'd3) state_nxt = FIN;
                else if (cmdOp == 2'd0)            state_nxt = LAYER;
                else if (cmdOp == 2'd1)            state_nxt = WFILL;
                else                               state_nxt = BIAS;
            end
            LAYER, BIAS: if (beat && last_entry) state_nxt = FIN;
            WFILL:       if (beat && last_word) state_nxt = WWRITE;
            WWRITE:      state_nxt = last_entry ? FIN : WFILL;
            FIN:         state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        // Abort wins over everything, including a beat offered in the same cycle.
        if (stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge pcieRst) begin
        if (!pcieRst) begin
            op              <= '0;
            base            <= '0;
            len             <= '0;
            entry           <= '0;
            word            <= '0;
            pack            <= '0;
            layerWriteEn    <= 1'b0;
            writeLayerData  <= '0;
            layerDataAddr   <= '0;
            weightWriteEn   <= 1'b0;
            writeWeightData <= '0;
            weightDataAddr  <= '0;
            biasWriteEn     <= 1'b0;
            writeBiasData   <= '0;
            biasDataAddr    <= '0;
            done            <= 1'b0;
            doneOp          <= '0;
            aborted         <= 1'b0;
        end else begin
            layerWriteEn  <= 1'b0;
            weightWriteEn <= 1'b0;
            biasWriteEn   <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            if (accept) begin
                op    <= cmdOp;
                base  <= cmdAddr;
                len   <= cmdLen;
                entry <= '0;
                word  <= '0;
                pack  <= '0;
            end else if (stop) begin
                aborted <= 1'b1;
                word    <= '0;
                pack    <= '0;
            end else begin
                case (state)
                    LAYER: if (beat) begin
                        layerWriteEn   <= 1'b1;
                        writeLayerData <= hostData;
                        layerDataAddr  <= cur_addr;
                        entry          <= entry_inc;
                    end
                    BIAS: if (beat) begin
                        biasWriteEn   <= 1'b1;
                        writeBiasData <= hostData[BIAS_W-1:0];
                        biasDataAddr  <= cur_addr[BADDR_W-1:0];
                        entry         <= entry_inc;
                    end
                    WFILL: if (beat) begin
                        for (int k = 0; k < WPE - 1; k++)
                            if (word == WCNT_W'(k)) pack[k*HOST_W +: HOST_W] <= hostData;
                        // The final word only partly fits; its upper bits are dropped.
                        if (last_word) pack[WEIGHT_W-1 -: LAST_W] <= hostData[LAST_W-1:0];
                        word <= last_word ? '0 : word + 1'b1;
                    end
                    WWRITE: begin
                        weightWriteEn   <= 1'b1;
                        writeWeightData <= pack;
                        weightDataAddr  <= cur_addr[WADDR_W-1:0];
                        pack            <= '0;
                        entry           <= entry_inc;
                    end
                    FIN: begin
                        done   <= 1'b1;
                        doneOp <= op;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pcie_param_loader.sv
// Randomised and directed bench for pcie_param_loader, checked every cycle against
// a transaction-level model plus a few hand-computed expectations.
module tb_pcie_param_loader;
    localparam int HOST_W   = 32;
    localparam int WEIGHT_W = 1936;
    localparam int WADDR_W  = 10;
    localparam int BIAS_W   = 16;
    localparam int BADDR_W  = 1;
    localparam int LADDR_W  = 18;
    localparam int WPE      = (WEIGHT_W + HOST_W - 1) / HOST_W;

    logic                clk = 1'b0;
    logic                pcieRst = 1'b0;
    logic                cmdValid = 1'b0, cmdAbort = 1'b0, hostValid = 1'b0;
    logic [1:0]          cmdOp = '0;
    logic [LADDR_W-1:0]  cmdAddr = '0, cmdLen = '0;
    logic [HOST_W-1:0]   hostData = '0;
    logic                cmdReady, hostReady, layerWriteEn, weightWriteEn, biasWriteEn;
    logic                busy, done, aborted;
    logic [HOST_W-1:0]   writeLayerData;
    logic [LADDR_W-1:0]  layerDataAddr;
    logic [WEIGHT_W-1:0] writeWeightData;
    logic [WADDR_W-1:0]  weightDataAddr;
    logic [BIAS_W-1:0]   writeBiasData;
    logic [BADDR_W-1:0]  biasDataAddr;
    logic [1:0]          doneOp;

    always #5 clk = ~clk;

    pcie_param_loader dut (
        .clk(clk), .pcieRst(pcieRst), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdAddr(cmdAddr), .cmdLen(cmdLen), .cmdAbort(cmdAbort),
        .hostData(hostData), .hostValid(hostValid), .hostReady(hostReady),
        .layerWriteEn(layerWriteEn), .writeLayerData(writeLayerData), .layerDataAddr(layerDataAddr),
        .weightWriteEn(weightWriteEn), .writeWeightData(writeWeightData), .weightDataAddr(weightDataAddr),
        .biasWriteEn(biasWriteEn), .writeBiasData(writeBiasData), .biasDataAddr(biasDataAddr),
        .busy(busy), .done(done), .doneOp(doneOp), .aborted(aborted)
    );

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;

    // Transaction-level model: a command is a number of beats; weight commands
    // group WPE words per entry and then spend one cycle writing it out.
    bit m_busy, m_gap, m_fin;
    int m_op, m_base, m_len, m_got, m_ent, m_beats;
    logic [HOST_W-1:0]   m_words[$];
    logic                e_lwe, e_wwe, e_bwe, e_done, e_aborted;
    logic [HOST_W-1:0]   e_ldata;
    logic [LADDR_W-1:0]  e_laddr;
    logic [WEIGHT_W-1:0] e_wdata;
    logic [WADDR_W-1:0]  e_waddr;
    logic [BIAS_W-1:0]   e_bdata;
    logic [BADDR_W-1:0]  e_baddr;
    logic [1:0]          e_doneop;

    typedef struct { int cyc; int addr; logic [HOST_W-1:0] data; } wr_t;
    wr_t l_log[$], b_log[$];
    int w_cyc[$], w_addr[$], done_cyc[$], done_op[$], abort_cyc[$];
    logic [WEIGHT_W-1:0] w_data[$];
    logic [HOST_W-1:0]   tx_q[$];

    task automatic m_reset();
        m_busy = 0; m_gap = 0; m_fin = 0; m_op = 0; m_base = 0; m_len = 0;
        m_got = 0; m_ent = 0; m_beats = 0; m_words.delete();
        e_lwe = 0; e_wwe = 0; e_bwe = 0; e_done = 0; e_aborted = 0;
        e_ldata = '0; e_laddr = '0; e_wdata = '0; e_waddr = '0;
        e_bdata = '0; e_baddr = '0; e_doneop = '0;
    endtask

    function automatic bit exp_hready();
        return m_busy && !m_gap && !m_fin;
    endfunction

    task automatic step();
        logic [WPE*HOST_W-1:0] tmp;
        e_lwe = 0; e_wwe = 0; e_bwe = 0; e_done = 0; e_aborted = 0;
        if (!m_busy) begin
            if (cmdValid) begin
                m_busy = 1; m_op = int'(cmdOp); m_base = int'(cmdAddr); m_len = int'(cmdLen);
                m_got = 0; m_ent = 0; m_beats = 0; m_gap = 0; m_words.delete();
                m_fin = (m_len == 0) || (m_op == 3);
            end
        end else if (cmdAbort) begin
            e_aborted = 1; m_busy = 0;
        end else if (m_fin) begin
            e_done = 1; e_doneop = 2'(m_op); m_busy = 0;
        end else if (m_gap) begin
            tmp = '0;
            foreach (m_words[i]) tmp[i*HOST_W +: HOST_W] = m_words[i];
            e_wwe = 1; e_wdata = tmp[WEIGHT_W-1:0];
            e_waddr = WADDR_W'((m_base + m_ent) % (1 << WADDR_W));
            m_ent++; m_words.delete(); m_gap = 0; m_fin = (m_ent == m_len);
        end else if (hostValid) begin
            m_beats++;
            if (m_op == 1) begin
                m_words.push_back(hostData);
                m_gap = (m_words.size() == WPE);
            end else begin
                if (m_op == 0) begin
                    e_lwe = 1; e_ldata = hostData;
                    e_laddr = LADDR_W'((m_base + m_got) % (1 << LADDR_W));
                end else begin
                    e_bwe = 1; e_bdata = hostData[BIAS_W-1:0];
                    e_baddr = BADDR_W'((m_base + m_got) % (1 << BADDR_W));
                end
                m_got++; m_fin = (m_got == m_len);
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check();
        logic [WPE*HOST_W-1:0] pa, pe;
        cmp("cmdReady", 64'(cmdReady), 64'(!m_busy));
        cmp("hostReady", 64'(hostReady), 64'(exp_hready()));
        cmp("busy", 64'(busy), 64'(m_busy));
        cmp("layerWriteEn", 64'(layerWriteEn), 64'(e_lwe));
        cmp("writeLayerData", 64'(writeLayerData), 64'(e_ldata));
        cmp("layerDataAddr", 64'(layerDataAddr), 64'(e_laddr));
        cmp("weightWriteEn", 64'(weightWriteEn), 64'(e_wwe));
        cmp("weightDataAddr", 64'(weightDataAddr), 64'(e_waddr));
        cmp("biasWriteEn", 64'(biasWriteEn), 64'(e_bwe));
        cmp("writeBiasData", 64'(writeBiasData), 64'(e_bdata));
        cmp("biasDataAddr", 64'(biasDataAddr), 64'(e_baddr));
        cmp("done", 64'(done), 64'(e_done));
        cmp("doneOp", 64'(doneOp), 64'(e_doneop));
        cmp("aborted", 64'(aborted), 64'(e_aborted));
        total++;
        if (writeWeightData !== e_wdata) begin
            bad++;
            pa = (WPE*HOST_W)'(writeWeightData);
            pe = (WPE*HOST_W)'(e_wdata);
            for (int j = 0; j < WPE; j++)
                if (pa[j*HOST_W +: HOST_W] !== pe[j*HOST_W +: HOST_W]) begin
                    if (bad <= 40) $display("FAIL writeWeightData word %0d at cyc %0d: got %h want %h",
                                            j, cyc, pa[j*HOST_W +: HOST_W], pe[j*HOST_W +: HOST_W]);
                    break;
                end
        end
        if (layerWriteEn) l_log.push_back('{cyc, int'(layerDataAddr), writeLayerData});
        if (biasWriteEn)  b_log.push_back('{cyc, int'(biasDataAddr), HOST_W'(writeBiasData)});
        if (weightWriteEn) begin
            w_cyc.push_back(cyc); w_addr.push_back(int'(weightDataAddr)); w_data.push_back(writeWeightData);
        end
        if (done) begin done_cyc.push_back(cyc); done_op.push_back(int'(doneOp)); end
        if (aborted) abort_cyc.push_back(cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!pcieRst) m_reset();
        else step();
        @(negedge clk);
        check();
    endtask

    task automatic clear_logs();
        l_log.delete(); b_log.delete(); w_cyc.delete(); w_addr.delete(); w_data.delete();
        done_cyc.delete(); done_op.delete(); abort_cyc.delete();
    endtask

    // vpct < 0 means hostValid alternates every cycle; abort_at/stop_at < 0 disable.
    task automatic run_cmd(input int op, input int addr, input int len, input int vpct,
                           input int abort_at, input int stop_at);
        bit sent, take;
        int guard;
        sent = 0; guard = 0;
        while (!sent || m_busy) begin
            if (guard > 3000) begin
                total++; bad++;
                $display("FAIL timeout at cyc %0d: command still busy, want idle", cyc);
                break;
            end
            if (stop_at >= 0 && sent && m_beats >= stop_at) begin
                hostValid = 0; cmdValid = 0;
                return;
            end
            if (!sent) begin
                cmdValid = 1; cmdOp = 2'(op); cmdAddr = LADDR_W'(addr); cmdLen = LADDR_W'(len);
            end else begin
                cmdValid = 1'($urandom_range(1)); cmdOp = 2'($urandom);
                cmdAddr = LADDR_W'($urandom); cmdLen = LADDR_W'($urandom);
            end
            hostValid = (vpct < 0) ? 1'(cyc % 2) : ($urandom_range(99) < vpct);
            hostData  = (tx_q.size() > 0) ? tx_q[0] : $urandom;
            cmdAbort  = 0;
            if (sent && abort_at >= 0 && exp_hready() && m_beats >= abort_at) begin
                cmdAbort = 1; hostValid = 0;
            end
            take = hostValid && exp_hready();
            if (!sent && !m_busy) begin sent = 1; acc_cyc = cyc + 1; end
            tick();
            if (take && tx_q.size() > 0) void'(tx_q.pop_front());
            guard++;
        end
        cmdValid = 0; hostValid = 0; cmdAbort = 0;
    endtask

    initial begin
        m_reset();
        repeat (3) tick();
        cmp("reset layerWriteEn", 64'(layerWriteEn), 64'd0);
        cmp("reset writeWeightData", 64'(writeWeightData[63:0]), 64'd0);
        cmp("reset doneOp", 64'(doneOp), 64'd0);
        cmp("reset cmdReady", 64'(cmdReady), 64'd1);
        pcieRst = 1;
        tick();

        // Back-to-back layer burst.
        clear_logs();
        for (int i = 0; i < 4; i++) tx_q.push_back(32'hA0 + 32'(i));
        run_cmd(0, 'h10, 4, 100, -1, -1);
        cmp("layer strobe count", 64'(l_log.size()), 64'd4);
        foreach (l_log[i]) begin
            cmp("layer addr", 64'(l_log[i].addr), 64'('h10 + i));
            cmp("layer data", 64'(l_log[i].data), 64'('hA0 + i));
            cmp("layer strobe latency", 64'(l_log[i].cyc - acc_cyc), 64'(i + 1));
        end
        cmp("layer done count", 64'(done_cyc.size()), 64'd1);
        if (done_cyc.size() == 1) begin
            cmp("layer done latency", 64'(done_cyc[0] - acc_cyc), 64'd5);
            cmp("layer doneOp", 64'(done_op[0]), 64'd0);
        end

        // Two weight entries from 122 words.
        clear_logs();
        for (int i = 0; i < 2 * WPE; i++) tx_q.push_back(32'hAB000100 + 32'(i << 16) + 32'(i));
        run_cmd(1, 3, 2, 100, -1, -1);
        cmp("weight strobe count", 64'(w_cyc.size()), 64'd2);
        if (w_cyc.size() == 2) begin
            cmp("weight addr0", 64'(w_addr[0]), 64'd3);
            cmp("weight addr1", 64'(w_addr[1]), 64'd4);
            cmp("weight e0 low word", 64'(w_data[0][31:0]), 64'h AB000100);
            cmp("weight e0 top half", 64'(w_data[0][1935:1920]), 64'h013C);
            cmp("weight e1 low word", 64'(w_data[1][31:0]), 64'h AB3D013D);
            cmp("weight strobe0 latency", 64'(w_cyc[0] - acc_cyc), 64'd62);
            cmp("weight strobe spacing", 64'(w_cyc[1] - w_cyc[0]), 64'd62);
        end
        cmp("weight done count", 64'(done_cyc.size()), 64'd1);

        // Bias with address wrap.
        clear_logs();
        tx_q.push_back(32'h12345678); tx_q.push_back(32'h0000BEEF);
        run_cmd(2, 1, 2, 100, -1, -1);
        cmp("bias strobe count", 64'(b_log.size()), 64'd2);
        if (b_log.size() == 2) begin
            cmp("bias addr0", 64'(b_log[0].addr), 64'd1);
            cmp("bias data0", 64'(b_log[0].data), 64'h5678);
            cmp("bias addr1", 64'(b_log[1].addr), 64'd0);
            cmp("bias data1", 64'(b_log[1].data), 64'hBEEF);
        end

        // Zero-length and illegal-op commands.
        for (int t = 0; t < 2; t++) begin
            clear_logs();
            run_cmd(t == 0 ? 0 : 3, 5, t == 0 ? 0 : 5, 100, -1, -1);
            cmp("empty cmd strobes", 64'(l_log.size() + b_log.size() + w_cyc.size()), 64'd0);
            cmp("empty cmd done count", 64'(done_cyc.size()), 64'd1);
            if (done_cyc.size() == 1) begin
                cmp("empty cmd done latency", 64'(done_cyc[0] - acc_cyc), 64'd1);
                cmp("empty cmd doneOp", 64'(done_op[0]), t == 0 ? 64'd0 : 64'd3);
            end
        end

        // Abort a half-filled weight entry, then clean bias and weight commands.
        clear_logs();
        run_cmd(1, 9, 1, 100, 30, -1);
        cmp("abort pulse count", 64'(abort_cyc.size()), 64'd1);
        cmp("abort weight strobes", 64'(w_cyc.size()), 64'd0);
        cmp("abort done count", 64'(done_cyc.size()), 64'd0);
        clear_logs();
        tx_q.push_back(32'h0000CAFE);
        run_cmd(2, 0, 1, 100, -1, -1);
        cmp("post-abort bias count", 64'(b_log.size()), 64'd1);
        if (b_log.size() == 1) cmp("post-abort bias data", 64'(b_log[0].data), 64'hCAFE);
        cmp("post-abort doneOp", 64'(doneOp), 64'd2);
        run_cmd(1, 0, 1, 70, -1, -1);

        // Stalling stream: hostValid every other cycle.
        clear_logs();
        run_cmd(0, 'h200, 8, -1, -1, -1);
        cmp("stall strobe count", 64'(l_log.size()), 64'd8);
        foreach (l_log[i]) cmp("stall addr", 64'(l_log[i].addr), 64'('h200 + i));

        // Random commands, occasional aborts and busy-time command noise.
        for (int n = 0; n < 30; n++) begin
            int op, len, ab;
            op  = int'($urandom_range(3));
            len = (op == 1) ? int'($urandom_range(2)) : int'($urandom_range(12));
            ab  = ($urandom_range(5) == 0) ? int'($urandom_range(40)) : -1;
            run_cmd(op, int'($urandom_range((1 << LADDR_W) - 1)), len,
                    int'($urandom_range(100, 30)), ab, -1);
        end

        // Reset in the middle of a wrapping layer burst.
        run_cmd(0, 'h3FFFE, 8, 100, -1, 3);
        #2 pcieRst = 0;
        #1;
        cmp("async rst busy", 64'(busy), 64'd0);
        cmp("async rst layerWriteEn", 64'(layerWriteEn), 64'd0);
        cmp("async rst layerDataAddr", 64'(layerDataAddr), 64'd0);
        cmp("async rst writeLayerData", 64'(writeLayerData), 64'd0);
        cmp("async rst doneOp", 64'(doneOp), 64'd0);
        m_reset();
        tx_q.delete();
        repeat (2) tick();
        pcieRst = 1;
        tick();
        clear_logs();
        run_cmd(0, 'h3FFFF, 2, 100, -1, -1);
        cmp("wrap strobe count", 64'(l_log.size()), 64'd2);
        if (l_log.size() == 2) cmp("wrap addr", 64'(l_log[1].addr), 64'd0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
